// File: rtl/id_ex_stage.sv
// Decode-to-execute pipeline register with operand forwarding, load-use stall detection
// and bubble insertion on stall or flush.
module id_ex_stage #(
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned ADDR_W  = 5,
   parameter int unsigned ALUOP_W = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               id_valid,
   input  logic [ADDR_W-1:0]  id_rs,
   input  logic [ADDR_W-1:0]  id_rt,
   input  logic [ADDR_W-1:0]  id_rd,
   input  logic [DATA_W-1:0]  id_data1,
   input  logic [DATA_W-1:0]  id_data2,
   input  logic [DATA_W-1:0]  id_imm,
   input  logic               id_reg_write,
   input  logic               id_mem_read,
   input  logic               id_mem_write,
   input  logic [ALUOP_W-1:0] id_alu_op,
   input  logic [DATA_W-1:0]  ex_result,
   input  logic               wb_write,
   input  logic [ADDR_W-1:0]  wb_addr,
   input  logic [DATA_W-1:0]  wb_data,
   input  logic               flush,
   output logic               stall,
   output logic               ex_valid,
   output logic [DATA_W-1:0]  ex_a,
   output logic [DATA_W-1:0]  ex_b,
   output logic [DATA_W-1:0]  ex_imm,
   output logic [ADDR_W-1:0]  ex_rd,
   output logic               ex_reg_write,
   output logic               ex_mem_read,
   output logic               ex_mem_write,
   output logic [ALUOP_W-1:0] ex_alu_op
);

   logic               valid_q;
   logic [DATA_W-1:0]  a_q, b_q, imm_q;
   logic [ADDR_W-1:0]  rd_q;
   logic               reg_write_q, mem_read_q, mem_write_q;
   logic [ALUOP_W-1:0] alu_op_q;

   logic              ex_fwd_en;
   logic              bubble;
   logic [DATA_W-1:0] fwd_a, fwd_b;

   // A load's result is not in ex_result yet, so it must never be forwarded from EX.
   assign ex_fwd_en = valid_q & reg_write_q & ~mem_read_q & (rd_q != '0);

   always_comb begin
      fwd_a = id_data1;
      if (id_rs == '0) begin
         fwd_a = '0;
      end else if (ex_fwd_en && (rd_q == id_rs)) begin
         fwd_a = ex_result;
      end else if (wb_write && (wb_addr == id_rs)) begin
         fwd_a = wb_data;
      end
   end

   always_comb begin
      fwd_b = id_data2;
      if (id_rt == '0) begin
         fwd_b = '0;
      end else if (ex_fwd_en && (rd_q == id_rt)) begin
         fwd_b = ex_result;
      end else if (wb_write && (wb_addr == id_rt)) begin
         fwd_b = wb_data;
      end
   end

   assign stall = ~rst & id_valid & valid_q & mem_read_q & (rd_q != '0) &
                  ((rd_q == id_rs) | (rd_q == id_rt)) & ~flush;
   assign bubble = flush | stall;

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q     <= 1'b0;
         a_q         <= '0;
         b_q         <= '0;
         imm_q       <= '0;
         rd_q        <= '0;
         reg_write_q <= 1'b0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         alu_op_q    <= '0;
      end else begin
         // Data fields load unconditionally; a bubble is defined by valid and controls alone.
         a_q      <= fwd_a;
         b_q      <= fwd_b;
         imm_q    <= id_imm;
         rd_q     <= id_rd;
         alu_op_q <= id_alu_op;
         if (bubble) begin
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
         end else begin
            valid_q     <= id_valid;
            reg_write_q <= id_reg_write & id_valid;
            mem_read_q  <= id_mem_read & id_valid;
            mem_write_q <= id_mem_write & id_valid;
         end
      end
   end

   assign ex_valid     = valid_q;
   assign ex_a         = a_q;
   assign ex_b         = b_q;
   assign ex_imm       = imm_q;
   assign ex_rd        = rd_q;
   assign ex_reg_write = reg_write_q;
   assign ex_mem_read  = mem_read_q;
   assign ex_mem_write = mem_write_q;
   assign ex_alu_op    = alu_op_q;

endmodule
